// File: rtl/pico_axi_rd_downsizer_pkg.sv
// Shared types for the pico AXI read downsizer: response codes, FSM states and beat metadata.
package pico_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ds_state_e;

    // Width-independent part of a buffered beat; the module wraps it with id/data fields.
    typedef struct packed {
        logic [1:0] resp;
        logic       last;
    } beat_meta_t;

endpackage

// File: rtl/pico_axi_rd_downsizer_if.sv
// AXI read-data channel bundle; the slave modport drives data, the master modport drives rready.
interface pico_axi_rd_downsizer_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 128
);
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave  (output rid, rdata, rresp, rlast, rvalid, input  rready);
    modport master (input  rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

// File: rtl/pico_axi_rd_downsizer_sync_fifo.sv
// Synchronous FIFO with async active-low reset; head entry is visible on o_rdata while non-empty.
module pico_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; memory is cleared so outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pico_axi_rd_downsizer.sv
// R-channel downsizer: splits wide master beats into narrow slave beats under a burst-command queue.
// Optional sticky rlast-consistency check enabled by defining PICO_AXI_DS_CHECK_EN.
module pico_axi_rd_downsizer
    import pico_axi_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH         = 8,
    parameter int C_AXI_SLAVE_DATA_WIDTH = 128,
    parameter int UPSIZE_RATIO           = 2,
    parameter int CMD_FIFO_DEPTH         = 4,
    localparam int CW = (UPSIZE_RATIO > 1) ? $clog2(UPSIZE_RATIO) : 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [CW-1:0]                  cmd_start_chunk,
    input  logic [7:0]                     cmd_len,
    pico_axi_rd_downsizer_if.slave         s_axi,
    pico_axi_rd_downsizer_if.master        m_axi,
    output logic                           err_protocol
);
    localparam int W  = C_AXI_SLAVE_DATA_WIDTH;
    localparam int MW = UPSIZE_RATIO * W;

    if (UPSIZE_RATIO == 1) begin : g_bypass
        logic w_unused_bypass;

        assign s_axi.rid     = m_axi.rid;
        assign s_axi.rdata   = m_axi.rdata;
        assign s_axi.rresp   = m_axi.rresp;
        assign s_axi.rlast   = m_axi.rlast;
        assign s_axi.rvalid  = m_axi.rvalid;
        assign m_axi.rready  = s_axi.rready;
        assign cmd_ready     = 1'b1;
        assign err_protocol  = 1'b0;
        assign w_unused_bypass = ^{aclk, aresetn, cmd_valid, cmd_start_chunk, cmd_len};
    end else begin : g_ds
        typedef struct packed {
            logic [C_AXI_ID_WIDTH-1:0] id;
            beat_meta_t                meta;
            logic [MW-1:0]             data;
        } beat_t;

        localparam int BW = $bits(beat_t);
        localparam logic [0:0] S_IDLE   = ST_IDLE;
        localparam logic [0:0] S_STREAM = ST_STREAM;

        logic                             w_cmd_push;
        logic                             w_cmd_pop;
        logic                             w_cmd_full;
        logic                             w_cmd_empty;
        logic [CW+7:0]                    w_cmd_rdata;
        logic                             w_beat_push;
        logic                             w_beat_pop;
        logic                             w_beat_full;
        logic                             w_beat_empty;
        logic [BW-1:0]                    w_beat_wdata;
        logic [BW-1:0]                    w_beat_rdata;
        beat_t                            w_head;
        logic [UPSIZE_RATIO-1:0][W-1:0]   w_chunks;
        logic                             w_hs;
        logic                             w_wrap;
        logic                             w_streaming;
        logic [0:0]                       r_state;
        logic [CW-1:0]                    r_ptr;
        logic [7:0]                       r_left;

        assign cmd_ready    = aresetn & ~w_cmd_full;
        assign w_cmd_push   = cmd_valid & cmd_ready;
        assign m_axi.rready = aresetn & ~w_beat_full;
        assign w_beat_push  = m_axi.rvalid & m_axi.rready;
        assign w_beat_wdata = {m_axi.rid, m_axi.rresp, m_axi.rlast, m_axi.rdata};

        pico_sync_fifo #(.WIDTH(CW + 8), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
            .clk     (aclk),
            .rst_n   (aresetn),
            .i_push  (w_cmd_push),
            .i_wdata ({cmd_start_chunk, cmd_len}),
            .i_pop   (w_cmd_pop),
            .o_rdata (w_cmd_rdata),
            .o_full  (w_cmd_full),
            .o_empty (w_cmd_empty)
        );

        pico_sync_fifo #(.WIDTH(BW), .DEPTH(2)) u_beat_fifo (
            .clk     (aclk),
            .rst_n   (aresetn),
            .i_push  (w_beat_push),
            .i_wdata (w_beat_wdata),
            .i_pop   (w_beat_pop),
            .o_rdata (w_beat_rdata),
            .o_full  (w_beat_full),
            .o_empty (w_beat_empty)
        );

        assign w_head      = beat_t'(w_beat_rdata);
        assign w_chunks    = w_head.data;
        assign w_streaming = (r_state == S_STREAM);

        assign s_axi.rvalid = w_streaming & ~w_beat_empty;
        assign s_axi.rdata  = w_chunks[r_ptr];
        assign s_axi.rid    = w_head.id;
        assign s_axi.rresp  = w_head.meta.resp;
        assign s_axi.rlast  = w_streaming & (r_left == 8'd0);

        // Queue pops: commands leave in IDLE, a beat leaves on its last chunk or at burst end.
        always_comb begin
            w_cmd_pop  = 1'b0;
            w_hs       = 1'b0;
            w_wrap     = (r_ptr == CW'(UPSIZE_RATIO - 1));
            w_beat_pop = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_cmd_pop = ~w_cmd_empty;
                end
                S_STREAM: begin
                    w_hs       = ~w_beat_empty & s_axi.rready;
                    w_beat_pop = w_hs & ((r_left == 8'd0) | w_wrap);
                end
                default: begin
                    w_cmd_pop = 1'b0;
                end
            endcase
        end

        // Burst walker: loads a command, then advances chunk pointer and remaining count per beat.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_state <= S_IDLE;
                r_ptr   <= '0;
                r_left  <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_cmd_empty) begin
                            r_ptr   <= w_cmd_rdata[CW+7:8];
                            r_left  <= w_cmd_rdata[7:0];
                            r_state <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (w_hs) begin
                            if (r_left == 8'd0) begin
                                r_state <= S_IDLE;
                            end else if (w_wrap) begin
                                r_ptr  <= '0;
                                r_left <= r_left - 8'd1;
                            end else begin
                                r_ptr  <= r_ptr + CW'(1);
                                r_left <= r_left - 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

`ifdef PICO_AXI_DS_CHECK_EN
        logic r_err;

        // Sticky flag when the master's rlast disagrees with where the command says the burst ends.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_err <= 1'b0;
            end else if (w_beat_pop) begin
                if ((r_left == 8'd0) && !w_head.meta.last) begin
                    r_err <= 1'b1;
                end else if ((r_left != 8'd0) && w_head.meta.last) begin
                    r_err <= 1'b1;
                end
            end
        end

        assign err_protocol = r_err;
`else
        assign err_protocol = 1'b0;
`endif
    end

endmodule
